// File: rtl/mul_defs_pkg.sv
// rtl/mul_defs_pkg.sv - shared FSM encodings and legal operand widths for the multiplier/divider family
package mul_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NUM_LEGAL_WIDTHS = 5;

  function automatic bit legal_width(input int w);
    return (w == 4) || (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/seq_mul_adder.sv
// rtl/seq_mul_adder.sv - WIDTH-bit ripple adder with carry in/out used by the shift-add datapath
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - radix-2 sequential signed/unsigned multiplier, fixed WIDTH-cycle latency
module seq_mul
  import mul_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  // Bit 0 of the accumulator is always shifted out before it is read again, so it is not stored.
  logic [2*WIDTH-1:1] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign last      = (count == CW'(WIDTH - 1));

  // The most-negative value negates to itself, which read as unsigned is the correct magnitude.
  assign mag_a = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

  assign addend = mplier[0] ? mcand : '0;

  adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign step     = {cout, sum, acc[WIDTH-1:1]};
  assign prod_fix = neg ? -step : step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      out_prod <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc    <= step[2*WIDTH-1:1];
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last) begin
            out_prod <= prod_fix;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; legal values 4, 8, 16, 32, 64, matching the widths the Adder block supports.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: operand request is present.
REQ-005 SHALL have port in_ready, output, 1: block can accept a request.
REQ-006 SHALL have port in_signed, input, 1: 1 = both operands two's-complement; 0 = both unsigned.
REQ-007 SHALL have port in_a, input, WIDTH: multiplicand.
REQ-008 SHALL have port in_b, input, WIDTH: multiplier.
REQ-009 SHALL have port out_valid, output, 1: product is available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the product.
REQ-011 SHALL have port out_prod, output, 2*WIDTH: full-width product.
REQ-012 SHALL have port busy, output, 1: high in BUSY or DONE.

Function
REQ-013 SHALL implement the three-state FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 SHALL define accept as in_valid & in_ready on a rising edge; in_ready = (state==IDLE) only.
REQ-015 On accept, SHALL latch the operand magnitudes (|a|, |b| when in_signed=1, else raw), set neg = in_signed & (a[MSB]^b[MSB]), clear the accumulator, set count=0, and enter BUSY.
REQ-016 Each BUSY cycle SHALL run one radix-2 shift-add step: the upper accumulator half plus (mcand if mplier LSB=1, else 0) via one Adder instance (cin=0); {cout, sum, lower half} shifts right by 1; count increments.
REQ-017 SHALL leave BUSY on the edge where count==WIDTH-1 and enter DONE; fixed latency = WIDTH edges from accept to the first out_valid cycle, independent of operand values (zero operands included).
REQ-018 On the DONE entry edge, SHALL register out_prod as the two's-complement negation of the result when neg=1, else the unmodified result.
REQ-019 SHALL assert out_valid only in DONE and hold out_prod stable until out_valid & out_ready; that edge returns the FSM to IDLE.
REQ-020 SHALL ignore in_valid and all operand inputs while not in IDLE; operand changes during BUSY SHALL NOT affect the result.
REQ-021 Signed most-negative operands (e.g. -2^(WIDTH-1) squared) SHALL produce the exact product 2^(2*WIDTH-2); magnitudes are treated as WIDTH-bit unsigned.
REQ-022 SHALL cap throughput at one product per WIDTH+2 cycles with out_ready held high: accept, WIDTH steps, DONE/IDLE turnaround.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, count=0, accumulator=0, neg=0, out_prod=0, out_valid=0, busy=0, in_ready=1.
REQ-024 rst asserted mid-BUSY or in DONE SHALL abandon the operation and emit no product after release.

Structure
REQ-025 SHALL place the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the legal-WIDTH list in a shared header, mul_defs, for reuse by the future divider.
REQ-026 SHALL instantiate exactly one sub-module, the existing Adder with WIDTH=WIDTH; SHALL contain no other adder except the sign-fix negation logic.
REQ-027 SHALL have a step counter $clog2(WIDTH) bits wide.

Verification
REQ-028 Unsigned case: WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF, in_signed=0 -> out_prod=0xFFFFFFFE00000001, out_valid exactly 32 cycles after accept.
REQ-029 Signed case: a=-7 (0xFFFFFFF9), b=6, in_signed=1 -> out_prod=0xFFFFFFFFFFFFFFD6 (-42); a=b=0x80000000 signed -> 0x4000000000000000.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_prod stable, in_ready=0 throughout; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-031 Operands ignored when busy: toggle in_a/in_b/in_valid randomly during BUSY with a=3, b=5 latched -> out_prod=15, only one accept.
REQ-032 Reset mid-op: assert rst at step 10 -> all outputs at reset values immediately; after release no out_valid until a new accept; a fresh 2*3 yields 6.
REQ-033 Back-to-back: 100 random signed/unsigned pairs, out_ready=1, in_valid=1 -> all products match the reference model, one product every 34 cycles at WIDTH=32.
